// File: rtl/udp_rx_if.sv
// Beat bus between the IPv4 RX stage, the UDP RX stage and the application.
// master drives the *_i side (upstream/bench); slave is the udp_rx view.
interface udp_rx_if #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = $clog2(DATA_W/8+1)
);
    // valid_i qualifies start_i, cs_err_i, data_i and len_i. There is no ready:
    // every valid beat is consumed on the clock edge where valid_i is high.
    // cancel_i is unqualified. valid_o qualifies start_o, last_o, data_o, len_o;
    // cancel_o is a standalone one-cycle pulse.
    logic              valid_i;
    logic              start_i;
    logic              cancel_i;
    logic              cs_err_i;
    logic [DATA_W-1:0] data_i;
    logic [LEN_W-1:0]  len_i;
    logic              valid_o;
    logic              start_o;
    logic              last_o;
    logic              cancel_o;
    logic [DATA_W-1:0] data_o;
    logic [LEN_W-1:0]  len_o;
    logic [1:0]        dbg_state;

    modport master (
        output valid_i, start_i, cancel_i, cs_err_i, data_i, len_i,
        input  valid_o, start_o, last_o, cancel_o, data_o, len_o, dbg_state
    );

    modport slave (
        input  valid_i, start_i, cancel_i, cs_err_i, data_i, len_i,
        output valid_o, start_o, last_o, cancel_o, data_o, len_o, dbg_state
    );
endinterface

// File: rtl/udp_rx.sv
// UDP receive stage: parses the 8-byte header, filters on port, forwards payload.
// Optional macro UDP_SRC_PORT_MATCH_EN adds a source-port filter.
module udp_rx #(
    parameter int          DATA_W   = 16,
    parameter int          LEN_W    = $clog2(DATA_W/8+1),
    parameter logic [15:0] DST_PORT = 16'd18000,
    parameter logic [15:0] SRC_PORT = 16'd18000
) (
    input  logic     clk,
    input  logic     nreset,
    udp_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HEAD = 2'd1,
        S_DATA = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t            r_state, w_state_n;
    logic [1:0]        r_hidx, w_hidx_n;
    logic [15:0]       r_rem, w_rem_n;
    logic              r_first, w_first_n;
    logic              r_started, w_started_n;
    logic              r_valid, w_valid_n;
    logic              r_start, w_start_n;
    logic              r_last, w_last_n;
    logic              r_cancel, w_cancel_n;
    logic [DATA_W-1:0] r_data, w_data_n;
    logic [LEN_W-1:0]  r_len, w_len_n;
    logic              w_port_bad;

`ifdef UDP_SRC_PORT_MATCH_EN
    logic [15:0]       r_src, w_src_n;
    assign w_port_bad = (bus.data_i != DST_PORT) || (r_src != SRC_PORT);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) r_src <= '0;
        else         r_src <= w_src_n;
    end
`else
    assign w_port_bad = (bus.data_i != DST_PORT);
`endif

    // len_i is informational only: the UDP length field decides where payload ends.
    logic w_unused;
`ifdef UDP_SRC_PORT_MATCH_EN
    assign w_unused = ^bus.len_i;
`else
    assign w_unused = ^{bus.len_i, SRC_PORT};
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state   <= S_IDLE;
            r_hidx    <= '0;
            r_rem     <= '0;
            r_first   <= 1'b0;
            r_started <= 1'b0;
            r_valid   <= 1'b0;
            r_start   <= 1'b0;
            r_last    <= 1'b0;
            r_cancel  <= 1'b0;
            r_data    <= '0;
            r_len     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_hidx    <= w_hidx_n;
            r_rem     <= w_rem_n;
            r_first   <= w_first_n;
            r_started <= w_started_n;
            r_valid   <= w_valid_n;
            r_start   <= w_start_n;
            r_last    <= w_last_n;
            r_cancel  <= w_cancel_n;
            r_data    <= w_data_n;
            r_len     <= w_len_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_hidx_n    = r_hidx;
        w_rem_n     = r_rem;
        w_first_n   = r_first;
        w_started_n = r_started;
        w_valid_n   = 1'b0;
        w_start_n   = 1'b0;
        w_last_n    = 1'b0;
        w_cancel_n  = 1'b0;
        w_data_n    = '0;
        w_len_n     = '0;
`ifdef UDP_SRC_PORT_MATCH_EN
        w_src_n     = r_src;
`endif

        // r_started is only ever set between an emitted start_o and its last_o,
        // so it alone decides whether an abort must be signalled downstream.
        if (bus.cancel_i && (r_state != S_IDLE)) begin
            w_state_n   = S_IDLE;
            w_cancel_n  = r_started;
            w_started_n = 1'b0;
            w_first_n   = 1'b0;
        end else if (bus.valid_i && bus.start_i) begin
            w_cancel_n  = r_started;
            w_started_n = 1'b0;
            w_first_n   = 1'b0;
            w_hidx_n    = 2'd1;
            w_state_n   = bus.cs_err_i ? S_DROP : S_HEAD;
`ifdef UDP_SRC_PORT_MATCH_EN
            w_src_n     = bus.data_i;
`endif
        end else if (bus.valid_i) begin
            case (r_state)
                S_HEAD: begin
                    case (r_hidx)
                        2'd1: begin
                            if (w_port_bad) w_state_n = S_DROP;
                            else            w_hidx_n  = 2'd2;
                        end
                        2'd2: begin
                            if (bus.data_i < 16'd8) begin
                                w_state_n = S_DROP;
                            end else begin
                                w_rem_n  = bus.data_i - 16'd8;
                                w_hidx_n = 2'd3;
                            end
                        end
                        default: begin
                            if (r_rem == 16'd0) begin
                                w_state_n = S_IDLE;
                            end else begin
                                w_state_n = S_DATA;
                                w_first_n = 1'b1;
                            end
                        end
                    endcase
                end
                S_DATA: begin
                    w_valid_n   = 1'b1;
                    w_start_n   = r_first;
                    w_data_n    = bus.data_i;
                    w_first_n   = 1'b0;
                    w_started_n = 1'b1;
                    if (r_rem <= 16'd2) begin
                        w_last_n    = 1'b1;
                        w_len_n     = r_rem[LEN_W-1:0];
                        w_state_n   = S_IDLE;
                        w_started_n = 1'b0;
                    end else begin
                        w_len_n = LEN_W'(2);
                        w_rem_n = r_rem - 16'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.valid_o   = r_valid;
    assign bus.start_o   = r_start;
    assign bus.last_o    = r_last;
    assign bus.cancel_o  = r_cancel;
    assign bus.data_o    = r_data;
    assign bus.len_o     = r_len;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_udp_rx.sv
// Directed bench for udp_rx: header parsing, filtering, length tracking, aborts, reset.
module tb_udp_rx;

  localparam logic [15:0] PORT = 16'h4650;   // 18000
  localparam logic [21:0] Z    = 22'd0;

  logic clk;
  logic nreset;
  int   checks;
  int   failures;

  udp_rx_if bus ();

  udp_rx dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] ov(input logic v, input logic s, input logic l,
                                     input logic c, input logic [15:0] d, input logic [1:0] n);
    return {v, s, l, c, d, n};
  endfunction

  function automatic logic [21:0] obs();
    return {bus.valid_o, bus.start_o, bus.last_o, bus.cancel_o, bus.data_o, bus.len_o};
  endfunction

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    assert (got === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
  endtask

  // driver: present one cycle of input, then check the registered result
  task automatic step(input logic v, input logic s, input logic c, input logic e,
                      input logic [15:0] d, input logic [21:0] exp, input string tag);
    bus.valid_i  = v;
    bus.start_i  = s;
    bus.cancel_i = c;
    bus.cs_err_i = e;
    bus.data_i   = d;
    bus.len_i    = v ? 2'd2 : 2'd0;
    @(posedge clk);
    #1;
    check(tag, obs(), exp);
  endtask

  task automatic hdr(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                     input logic e, input string tag);
    step(1'b1, 1'b1, 1'b0, e,    src,   Z, {tag, "_h0"});
    step(1'b1, 1'b0, 1'b0, 1'b0, dst,   Z, {tag, "_h1"});
    step(1'b1, 1'b0, 1'b0, 1'b0, len,   Z, {tag, "_h2"});
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, Z, {tag, "_h3"});
  endtask

  task automatic pay(input logic [15:0] d, input logic [21:0] exp, input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, d, exp, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, Z, tag);
  endtask

  task automatic good_dg(input string tag);
    hdr(PORT, PORT, 16'd12, 1'b0, tag);
    pay(16'hDEAD, ov(1, 1, 0, 0, 16'hDEAD, 2'd2), {tag, "_p0"});
    pay(16'hBEEF, ov(1, 0, 1, 0, 16'hBEEF, 2'd2), {tag, "_p1"});
    idle({tag, "_idle"});
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    nreset      = 1'b0;
    bus.valid_i = 1'b0; bus.start_i = 1'b0; bus.cancel_i = 1'b0;
    bus.cs_err_i = 1'b0; bus.data_i = '0; bus.len_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", obs(), Z);
    check("reset_state", 22'(bus.dbg_state), 22'd0);
    nreset = 1'b1;
    idle("post_reset");

    // basic datagram, L=12
    good_dg("t1");

    // odd payload, L=11, then a trailer beat ignored in IDLE
    hdr(PORT, PORT, 16'd11, 1'b0, "t2");
    pay(16'h0102, ov(1, 1, 0, 0, 16'h0102, 2'd2), "t2_p0");
    pay(16'h0300, ov(1, 0, 1, 0, 16'h0300, 2'd1), "t2_p1");
    pay(16'h5555, Z, "t2_trailer");

    // single-byte payload, L=9: start and last on one beat
    hdr(PORT, PORT, 16'd9, 1'b0, "t2b");
    pay(16'hAB00, ov(1, 1, 1, 0, 16'hAB00, 2'd1), "t2b_p0");

    // dst mismatch swallowed, then a good datagram
    hdr(PORT, 16'h1234, 16'd12, 1'b0, "t3");
    pay(16'hDEAD, Z, "t3_p0");
    pay(16'hBEEF, Z, "t3_p1");
    good_dg("t3_next");

    // checksum error on the start beat
    hdr(PORT, PORT, 16'd12, 1'b1, "t4");
    pay(16'hDEAD, Z, "t4_p0");
    pay(16'hBEEF, Z, "t4_p1");
    // L=8 (empty payload) and L=7 (too short)
    hdr(PORT, PORT, 16'd8, 1'b0, "t4_l8");
    check("t4_l8_state", 22'(bus.dbg_state), 22'd0);
    pay(16'h1111, Z, "t4_l8_after");
    hdr(PORT, PORT, 16'd7, 1'b0, "t4_l7");
    pay(16'h2222, Z, "t4_l7_p0");
    good_dg("t4_next");

    // cancel after 3 payload beats of L=20
    hdr(PORT, PORT, 16'd20, 1'b0, "t5");
    check("t5_state", 22'(bus.dbg_state), 22'd2);
    pay(16'h0001, ov(1, 1, 0, 0, 16'h0001, 2'd2), "t5_p0");
    pay(16'h0002, ov(1, 0, 0, 0, 16'h0002, 2'd2), "t5_p1");
    pay(16'h0003, ov(1, 0, 0, 0, 16'h0003, 2'd2), "t5_p2");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, ov(0, 0, 0, 1, 16'h0, 2'd0), "t5_cancel");
    pay(16'h0004, Z, "t5_p3_dead");
    good_dg("t5_next");

    // cancel in HEAD (no start_o yet): no cancel_o; cancel in IDLE: nothing
    step(1'b1, 1'b1, 1'b0, 1'b0, PORT, Z, "t5b_h0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, Z, "t5b_cancel_head");
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, Z, "t5b_cancel_idle");

    // restart (new start) mid-DATA
    hdr(PORT, PORT, 16'd20, 1'b0, "t5c");
    pay(16'h0A0A, ov(1, 1, 0, 0, 16'h0A0A, 2'd2), "t5c_p0");
    step(1'b1, 1'b1, 1'b0, 1'b0, PORT, ov(0, 0, 0, 1, 16'h0, 2'd0), "t5c_restart");
    step(1'b1, 1'b0, 1'b0, 1'b0, PORT, Z, "t5c_h1");
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'd12, Z, "t5c_h2");
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, Z, "t5c_h3");
    pay(16'hCAFE, ov(1, 1, 0, 0, 16'hCAFE, 2'd2), "t5c_p0b");
    pay(16'hF00D, ov(1, 0, 1, 0, 16'hF00D, 2'd2), "t5c_p1b");

    // cancel together with start mid-DATA: cancel wins, start beat discarded
    hdr(PORT, PORT, 16'd20, 1'b0, "t5d");
    pay(16'h0B0B, ov(1, 1, 0, 0, 16'h0B0B, 2'd2), "t5d_p0");
    step(1'b1, 1'b1, 1'b1, 1'b0, PORT, ov(0, 0, 0, 1, 16'h0, 2'd0), "t5d_cancel_start");
    pay(PORT, Z, "t5d_stray");
    pay(16'd12, Z, "t5d_stray2");
    good_dg("t5d_next");

    // reset asserted mid-DATA clears outputs without a clock edge
    hdr(PORT, PORT, 16'd20, 1'b0, "t6");
    pay(16'h0C0C, ov(1, 1, 0, 0, 16'h0C0C, 2'd2), "t6_p0");
    #2;
    nreset = 1'b0;
    #1;
    check("t6_async_reset", obs(), Z);
    check("t6_reset_state", 22'(bus.dbg_state), 22'd0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    idle("t6_release");
    good_dg("t6_next");

    // source port 1
`ifdef UDP_SRC_PORT_MATCH_EN
    hdr(16'd1, PORT, 16'd12, 1'b0, "t7");
    pay(16'hDEAD, Z, "t7_p0");
    pay(16'hBEEF, Z, "t7_p1");
`else
    hdr(16'd1, PORT, 16'd12, 1'b0, "t7");
    pay(16'hDEAD, ov(1, 1, 0, 0, 16'hDEAD, 2'd2), "t7_p0");
    pay(16'hBEEF, ov(1, 0, 1, 0, 16'hBEEF, 2'd2), "t7_p1");
`endif
    idle("t7_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
